// File: rtl/bit_destuffer_if.sv
// Bit-level bus between the sample-point logic and the destuffer:
// SP/RX_bit/EN_STF in, destuffed bit, stuff-error flag and stuff count out.
interface bit_destuffer_if;
  logic       SP;
  logic       RX_bit;
  logic       EN_STF;
  logic       BIT_out;
  logic       BIT_valid;
  logic       STF_E;
  logic [7:0] STF_CNT;

  modport master (
    output SP, RX_bit, EN_STF,
    input  BIT_out, BIT_valid, STF_E, STF_CNT
  );

  modport slave (
    input  SP, RX_bit, EN_STF,
    output BIT_out, BIT_valid, STF_E, STF_CNT
  );
endinterface

// File: rtl/bit_destuffer.sv
// Removes stuff bits after RUN_LEN equal bits; one-clock registered output, error is sticky until reset.
// Define STF_CNT_EN to build the saturating stuff-bit counter; otherwise STF_CNT is tied to 0.
module bit_destuffer #(
  parameter int RUN_LEN = 5
) (
  input logic            clock,
  input logic            reset,
  bit_destuffer_if.slave bus
);
  localparam int RW = $clog2(RUN_LEN + 1);

  typedef enum logic [1:0] {IDLE, COUNT, EXPECT_STUFF, ERROR} state_t;

  localparam logic [RW-1:0] RUN_MAX = RW'(RUN_LEN);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);
  // A freshly started run is already complete when RUN_LEN is 1
  localparam state_t FIRST = (RUN_LEN == 1) ? EXPECT_STUFF : COUNT;

  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic          last_q, last_d;
  logic          out_q, out_d;
  logic          valid_q, valid_d;
  logic          stfe_q, stfe_d;

  assign run_inc = run_q + RUN_ONE;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    last_d  = last_q;
    out_d   = out_q;
    valid_d = 1'b0;
    stfe_d  = stfe_q;
    if (bus.SP && state_q != ERROR) begin
      if (!bus.EN_STF) begin
        valid_d = 1'b1;
        out_d   = bus.RX_bit;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            valid_d = 1'b1;
            out_d   = bus.RX_bit;
            run_d   = RUN_ONE;
            last_d  = bus.RX_bit;
            state_d = FIRST;
          end
          COUNT: begin
            valid_d = 1'b1;
            out_d   = bus.RX_bit;
            if (bus.RX_bit == last_q) begin
              run_d = run_inc;
              if (run_inc == RUN_MAX) state_d = EXPECT_STUFF;
            end else begin
              run_d   = RUN_ONE;
              last_d  = bus.RX_bit;
              state_d = FIRST;
            end
          end
          EXPECT_STUFF: begin
            // Stuff bit is dropped but opens the next run
            if (bus.RX_bit != last_q) begin
              run_d   = RUN_ONE;
              last_d  = bus.RX_bit;
              state_d = FIRST;
            end else begin
              stfe_d  = 1'b0;
              state_d = ERROR;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      run_q   <= '0;
      last_q  <= 1'b1;
      out_q   <= 1'b1;
      valid_q <= 1'b0;
      stfe_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      last_q  <= last_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      stfe_q  <= stfe_d;
    end
  end

  assign bus.BIT_out   = out_q;
  assign bus.BIT_valid = valid_q;
  assign bus.STF_E     = stfe_q;

`ifdef STF_CNT_EN
  logic       win_start, stuff_hit;
  logic [7:0] cnt_q;

  assign win_start = bus.SP && bus.EN_STF && state_q == IDLE;
  assign stuff_hit = bus.SP && bus.EN_STF && state_q == EXPECT_STUFF && bus.RX_bit != last_q;

  always_ff @(posedge clock) begin
    if (reset || win_start) cnt_q <= 8'd0;
    else if (stuff_hit && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
  end

  assign bus.STF_CNT = cnt_q;
`else
  assign bus.STF_CNT = 8'd0;
`endif
endmodule

// File: tb/tb_bit_destuffer.sv
// Directed and randomized checks of bit_destuffer against a bit-stream reference model.
module tb_bit_destuffer;
  localparam int RL = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  bit_destuffer_if bus();

  bit_destuffer #(.RUN_LEN(RL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  logic got[$];
  logic stim[$];
  logic exp_d[$];
  logic exp_err;
  int   exp_stf;
  logic hold_v  = 1'b1;
  logic prev_v  = 1'b0;
  bit   started = 1'b0;
  logic post_stfe;
  logic post_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: destuffed stream, stuff count and error flag of the whole frame
  function automatic void model(input logic en);
    int   run  = 0;
    logic prev = 1'b1;
    exp_d.delete();
    exp_err = 1'b0;
    exp_stf = 0;
    foreach (stim[i]) begin
      if (!en) exp_d.push_back(stim[i]);
      else if (exp_err) ;
      else if (run == RL) begin
        if (stim[i] == prev) exp_err = 1'b1;
        else begin
          exp_stf++;
          prev = stim[i];
          run  = 1;
        end
      end else begin
        exp_d.push_back(stim[i]);
        run  = (run != 0 && stim[i] == prev) ? run + 1 : 1;
        prev = stim[i];
      end
    end
  endfunction

  function automatic int exp_cnt(input int n);
`ifdef STF_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0 * n;
`endif
  endfunction

  always @(posedge clock) begin
    started = 1'b1;
    if (reset) hold_v = 1'b1;
  end

  always @(negedge clock) begin
    if (started) begin
      checks++;
      if (bus.BIT_valid) begin
        assert (!prev_v) else begin
          errors++;
          $error("FAIL valid_width: observed two-clock pulse expected one clock");
        end
        got.push_back(bus.BIT_out);
        hold_v = bus.BIT_out;
      end else begin
        assert (bus.BIT_out === hold_v) else begin
          errors++;
          $error("FAIL bit_out_hold: observed %b expected %b", bus.BIT_out, hold_v);
        end
      end
      prev_v = bus.BIT_valid;
    end
  end

  task automatic send(input logic b, input logic en);
    @(negedge clock);
    bus.SP = 1'b1; bus.RX_bit = b; bus.EN_STF = en;
    @(negedge clock);
    bus.SP = 1'b0;
    post_stfe = bus.STF_E;
    post_v    = bus.BIT_valid;
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; bus.SP = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    got.delete();
  endtask

  task automatic play_and_check(input logic en, input string tag);
    model(en);
    foreach (stim[i]) send(stim[i], en);
    repeat (2) @(negedge clock);
    chk({tag, "_count"}, got.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got.size(); i++)
      chk({tag, "_data"}, got[i], exp_d[i]);
    chk({tag, "_stf_e"}, bus.STF_E, !exp_err);
    chk({tag, "_stf_cnt"}, bus.STF_CNT, exp_cnt(exp_stf));
  endtask

  task automatic run_frame(input logic en, input string tag);
    do_reset();
    play_and_check(en, tag);
  endtask

  initial begin
    bus.SP = 1'b0; bus.RX_bit = 1'b1; bus.EN_STF = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_bit_out", bus.BIT_out, 1);
    chk("rst_bit_valid", bus.BIT_valid, 0);
    chk("rst_stf_e", bus.STF_E, 1);
    chk("rst_stf_cnt", bus.STF_CNT, 0);

    // Single stuff bit, last bit is data so its pulse lands one clock after SP
    stim = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    run_frame(1'b1, "stuff1");
    chk("latency_valid", post_v, 1);

    // Six equal bits: sticky error
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1);
      chk("err_stf_e_timing", post_stfe, (i < 5) ? 1 : 0);
    end
    send(1'b1, 1'b1);
    chk("err_stf_e_hold1", post_stfe, 0);
    send(1'b0, 1'b0);
    chk("err_stf_e_hold2", post_stfe, 0);
    send(1'b0, 1'b1);
    chk("err_stf_e_hold3", post_stfe, 0);
    repeat (2) @(negedge clock);
    chk("err_pulses", got.size(), 5);

    // Pass-through window
    stim = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_frame(1'b0, "pass");

    // EN_STF drop mid-run must abandon the run
    do_reset();
    send(1'b0, 1'b1);
    send(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) send(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1);
    send(1'b1, 1'b1);
    chk("idle_stuff_no_pulse", post_v, 0);
    repeat (2) @(negedge clock);
    chk("idle_count", got.size(), 14);
    for (int i = 0; i < got.size(); i++) chk("idle_data", got[i], 0);
    chk("idle_stf_e", bus.STF_E, 1);
    chk("idle_stf_cnt", bus.STF_CNT, exp_cnt(1));

    // Two stuff bits
    stim = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    run_frame(1'b1, "stuff2");

    // Reset mid-run, with SP on the reset clock
    do_reset();
    for (int i = 0; i < 4; i++) send(1'b0, 1'b1);
    got.delete();
    @(negedge clock);
    reset = 1'b1; bus.SP = 1'b1; bus.RX_bit = 1'b0; bus.EN_STF = 1'b1;
    @(negedge clock);
    reset = 1'b0; bus.SP = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_sp_discard", got.size(), 0);
    stim = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    play_and_check(1'b1, "after_rst");

    // 300 stuff bits in one window
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(1'b0);
    for (int k = 0; k < 300; k++)
      for (int i = 0; i < 5; i++) stim.push_back(k[0] ? 1'b0 : 1'b1);
    run_frame(1'b1, "sat");
    send(1'b0, 1'b0);
    send(1'b0, 1'b1);
    chk("sat_clear", bus.STF_CNT, 0);

    // Random frames built from runs of 1..5, occasionally 6
    for (int f = 0; f < 20; f++) begin
      int   len;
      logic v;
      len = $urandom_range(1, 40);
      v   = 1'($urandom_range(0, 1));
      stim.delete();
      while (stim.size() < len) begin
        int r;
        r = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(1, 5);
        for (int j = 0; j < r; j++) stim.push_back(v);
        v = ~v;
      end
      run_frame(1'b1, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_destuffer.md
BIT_DESTUFFER -- requirements
Module: bit_destuffer

Interface
REQ-001 The module SHALL have parameter RUN_LEN, default 5, giving the number of equal consecutive bits after which a stuff bit is expected.
REQ-002 The module SHALL have port clock, input, 1, the single rising-edge system clock.
REQ-003 The module SHALL have port reset, input, 1, a synchronous active-high reset sampled on the rising edge of clock.
REQ-004 The module SHALL have port SP, input, 1, a sample-point strobe that is high for exactly one clock per bus bit.
REQ-005 The module SHALL have port RX_bit, input, 1, the bus bit value, valid while SP=1.
REQ-006 The module SHALL have port EN_STF, input, 1, the destuffing-active window (SOF through CRC field), sampled together with SP.
REQ-007 The module SHALL have port BIT_out, output, 1, the destuffed data bit.
REQ-008 The module SHALL have port BIT_valid, output, 1, a one-clock pulse qualifying BIT_out.
REQ-009 The module SHALL have port STF_E, output, 1, an active-low stuff-error flag (1 = no error) that feeds the downstream error block.
REQ-010 The module SHALL have port STF_CNT, output, 8, the count of stuff bits removed in the current window.

Function
REQ-011 The module SHALL implement the states IDLE, COUNT, EXPECT_STUFF and ERROR, held in a state register.
REQ-012 The module SHALL keep a run counter with a range of 1..RUN_LEN and a last-bit register.
REQ-013 The module SHALL advance state, run counter and outputs only on clocks where SP=1, with two exceptions: the reset and BIT_valid deassertion.
REQ-014 IDLE, SP=1, EN_STF=0: the module SHALL pass RX_bit through as a data bit and stay in IDLE.
REQ-015 IDLE, SP=1, EN_STF=1: the module SHALL treat RX_bit as a data bit, set run=1, store last=RX_bit, and go to COUNT.
REQ-016 COUNT, SP=1, EN_STF=1, RX_bit==last: the module SHALL output the data bit and increment run; when run reaches RUN_LEN it SHALL go to EXPECT_STUFF.
REQ-017 COUNT, SP=1, EN_STF=1, RX_bit!=last: the module SHALL output the data bit, set run=1 and set last=RX_bit.
REQ-018 EXPECT_STUFF, SP=1, EN_STF=1, RX_bit!=last: the bit is a stuff bit, so the module SHALL NOT assert BIT_valid, SHALL set run=1 and last=RX_bit, and SHALL go to COUNT (the stuff bit starts the next run).
REQ-019 EXPECT_STUFF, SP=1, EN_STF=1, RX_bit==last: the module SHALL go to ERROR and drive STF_E=0 on the next clock.
REQ-020 In COUNT or EXPECT_STUFF with SP=1 and EN_STF=0, the module SHALL handle the bit exactly as in IDLE (pass-through, no stuff check) and SHALL return to IDLE.
REQ-021 ERROR: STF_E SHALL stay 0 and BIT_valid SHALL stay 0, regardless of SP and EN_STF, until reset.
REQ-022 Latency: BIT_valid and BIT_out SHALL be registered, asserting on the clock after the SP clock; BIT_valid SHALL be high for exactly one clock.
REQ-023 Between valid pulses, BIT_out SHALL hold its last value.
REQ-024 If reset and SP are high on the same clock, reset SHALL win and the bit SHALL be discarded.

Reset
REQ-025 On reset the module SHALL set state=IDLE, run=0, last=1 (recessive), BIT_out=1, BIT_valid=0, STF_E=1 and STF_CNT=0.
REQ-026 A reset asserted mid-frame SHALL abandon the run with no output pulse.

Configuration
REQ-027 With macro STF_CNT_EN defined, STF_CNT SHALL increment by 1 on each clock following a stuff bit (REQ-018).
REQ-028 With STF_CNT_EN defined, STF_CNT SHALL saturate at 255.
REQ-029 With STF_CNT_EN defined, STF_CNT SHALL clear to 0 on the SP clock that moves the state from IDLE to COUNT.
REQ-030 Without STF_CNT_EN, STF_CNT SHALL be driven constant 0 and no counter register SHALL be synthesised; all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover: EN_STF=1, bits 0,0,0,0,0,1(stuff),1,0 -> exactly 7 BIT_valid pulses with data 0,0,0,0,0,1,0; STF_E=1; STF_CNT=1 (macro on) or 0 (macro off).
REQ-032 The bench SHALL cover: EN_STF=1, six consecutive 1s -> STF_E=0 one clock after the sixth SP; no BIT_valid pulse for the sixth bit or after; STF_E stays 0 across further SP strobes until reset.
REQ-033 The bench SHALL cover: EN_STF=0, seven 0s -> 7 BIT_valid pulses, STF_E=1, state remains IDLE.
REQ-034 The bench SHALL cover: EN_STF=1, bits 1,1,1,1,1,0(stuff),0,0,0,0,1(stuff) -> 9 data pulses (1,1,1,1,1,0,0,0,0); STF_CNT=2 (macro on).
REQ-035 The bench SHALL cover: reset pulsed after the 4th equal bit, then EN_STF=1 with 0,0,0,0,0,1 -> the 1 is treated as a stuff bit (run restarted from reset), and STF_E=1.
REQ-036 The bench SHALL cover: macro on, 300 stuff bits inside one window -> STF_CNT saturates at 255; the next IDLE-to-COUNT start clears it to 0.
